// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter and its matching receiver:
// state encoding, line levels and a counter-width helper.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period divider: counts BAUD_DIV cycles while enabled and pulses bit_end
// on the last cycle of each period. Synchronous clear restarts the period.
module baud_tick_gen
  import serial_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic bit_end
);

  localparam int unsigned      CNT_W    = cnt_width(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    bit_end = en && (cnt_q == CNT_LAST);
    if (clear || bit_end) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W bits LSB-first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BAUD_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int unsigned      BIT_W    = cnt_width(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_out_q, tx_out_d;
  logic              bit_end;
  logic              handshake;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  baud_tick_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (handshake),
    .en      (state_q != IDLE),
    .bit_end (bit_end)
  );

  // Accepting in the last STOP cycle lets frames run back-to-back with no idle gap.
  assign tx_ready  = !rst && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  assign handshake = tx_valid && tx_ready;
  assign tx_out    = tx_out_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_out_d  = STOP_BIT;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (handshake) state_d = START;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = handshake ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (handshake) begin
      shift_d = tx_data;
`ifdef SERIAL_TX_PARITY_EN
      parity_d = ^tx_data;
`endif
    end

    // Line level is registered, so it follows the state being entered.
    case (state_d)
      START:  tx_out_d = START_BIT;
      DATA:   tx_out_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY: tx_out_d = parity_q;
`endif
      default: tx_out_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_out_q  <= IDLE_LEVEL;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_out_q  <= tx_out_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a default instance (8 bits, 4 clocks/bit) and a fast one
// (4 bits, 1 clock/bit) share stimulus and are checked every cycle against a frame model.
module tb_serial_frame_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB0   = 10 + PB;
  localparam int FLEN0 = NB0 * 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       rdy0, out0, busy0;
  logic       rdy1, out1, busy1;

  int  total = 0;
  int  bad   = 0;
  bit  chk_en = 1'b0;

  int   m_active [0:1] = '{0, 0};
  int   m_t      [0:1] = '{0, 0};
  int   m_len    [0:1] = '{1, 1};
  logic m_bits   [0:1][0:15];

  logic cap_out  [0:63];
  logic cap_busy [0:63];
  logic cap_rdy  [0:63];
  logic fcap_out [0:63];

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(8), .BAUD_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (rdy0),
    .tx_out   (out0),
    .busy     (busy0)
  );

  serial_frame_tx #(.DATA_W(4), .BAUD_DIV(1)) dut_fast (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data[3:0]),
    .tx_valid (tx_valid),
    .tx_ready (rdy1),
    .tx_out   (out1),
    .busy     (busy1)
  );

  function automatic int dw_of(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic int bd_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic exp_ready(input int i);
    return !rst && ((m_active[i] == 0) || (m_t[i] == m_len[i] - 1));
  endfunction

  function automatic logic exp_out(input int i);
    if (m_active[i] == 0) return 1'b1;
    return m_bits[i][m_t[i] / bd_of(i)];
  endfunction

  // Frame model: on an accepted word, lay out the whole frame as a bit list.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_active[i] = 0;
      end else if (tx_valid && exp_ready(i)) begin
        logic par;
        par = 1'b0;
        m_bits[i][0] = 1'b0;
        for (int k = 0; k < dw_of(i); k++) begin
          m_bits[i][1 + k] = tx_data[k];
          par ^= tx_data[k];
        end
        if (PB == 1) m_bits[i][dw_of(i) + 1] = par;
        m_bits[i][dw_of(i) + 1 + PB] = 1'b1;
        m_len[i]    = (2 + dw_of(i) + PB) * bd_of(i);
        m_t[i]      = 0;
        m_active[i] = 1;
      end else if (m_active[i] != 0) begin
        m_t[i] = m_t[i] + 1;
        if (m_t[i] == m_len[i]) m_active[i] = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("out0",  {31'b0, out0},  {31'b0, exp_out(0)});
      checkOutput("busy0", {31'b0, busy0}, {31'b0, m_active[0] != 0});
      checkOutput("rdy0",  {31'b0, rdy0},  {31'b0, exp_ready(0)});
      checkOutput("out1",  {31'b0, out1},  {31'b0, exp_out(1)});
      checkOutput("busy1", {31'b0, busy1}, {31'b0, m_active[1] != 0});
      checkOutput("rdy1",  {31'b0, rdy1},  {31'b0, exp_ready(1)});
    end
  end

  // One-cycle valid pulse; returns 3 time units after the accepting edge.
  task automatic applyStimulus(input logic [7:0] d);
    @(posedge clk);
    #3;
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #3;
    tx_valid = 1'b0;
  endtask

  task automatic captureFrame(input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      cap_out[t]  = out0;
      cap_busy[t] = busy0;
      cap_rdy[t]  = rdy0;
      fcap_out[t] = out1;
    end
  endtask

  function automatic logic [10:0] slowBits();
    logic [10:0] v;
    v = '0;
    for (int k = 0; k < NB0; k++) v[k] = cap_out[4 * k + 1];
    return v;
  endfunction

  task automatic waitIdle();
    int n;
    n = 0;
    while ((m_active[0] != 0 || m_active[1] != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #3;
    checkOutput("idle_timeout", {31'b0, n >= 200}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busy_cnt;
    int rdy_cnt;
    logic [10:0] fv;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    repeat (2) @(posedge clk);
    #3;
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("rdy_in_reset", {31'b0, rdy0}, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("idle_out",  {31'b0, out0},  32'd1);
      checkOutput("idle_busy", {31'b0, busy0}, 32'd0);
      checkOutput("idle_rdy",  {31'b0, rdy0},  32'd1);
    end

    $display("[TB] frame 0xA5");
    applyStimulus(8'hA5);
    captureFrame(44);
    busy_cnt = 0;
    rdy_cnt  = 0;
    for (int t = 0; t < 44; t++) begin
      if (cap_busy[t]) busy_cnt++;
      if (cap_busy[t] && cap_rdy[t]) rdy_cnt++;
    end
    checkOutput("a5_bits", {21'b0, slowBits()}, (PB == 1) ? 32'h54A : 32'h34A);
    checkOutput("a5_busy_len", busy_cnt, FLEN0);
    checkOutput("a5_rdy_count", rdy_cnt, 32'd1);
    checkOutput("a5_rdy_last", {31'b0, cap_rdy[FLEN0 - 1]}, 32'd1);
    waitIdle();

    $display("[TB] frame 0x09");
    applyStimulus(8'h09);
    captureFrame(8);
    fv = '0;
    for (int t = 0; t < 6 + PB; t++) fv[t] = fcap_out[t];
    checkOutput("fast_09_bits", {21'b0, fv}, (PB == 1) ? 32'h52 : 32'h32);
    waitIdle();

`ifdef SERIAL_TX_PARITY_EN
    $display("[TB] frame 0x07 parity");
    applyStimulus(8'h07);
    captureFrame(44);
    checkOutput("par_07", {31'b0, cap_out[37]}, 32'd1);
    waitIdle();
`endif

    $display("[TB] back-to-back 0x01 then 0x80");
    @(posedge clk);
    #3;
    tx_valid = 1'b1;
    tx_data  = 8'h01;
    @(posedge clk);
    #3;
    tx_data = 8'h80;
    captureFrame(FLEN0 + 4);
    @(posedge clk);
    #3;
    tx_valid = 1'b0;
    checkOutput("b2b_stop",   {31'b0, cap_out[FLEN0 - 1]},  32'd1);
    checkOutput("b2b_rdy",    {31'b0, cap_rdy[FLEN0 - 1]},  32'd1);
    checkOutput("b2b_start",  {31'b0, cap_out[FLEN0]},      32'd0);
    checkOutput("b2b_busy",   {31'b0, cap_busy[FLEN0]},     32'd1);
    checkOutput("b2b_start3", {31'b0, cap_out[FLEN0 + 3]},  32'd0);
    waitIdle();

    $display("[TB] reset mid-frame");
    applyStimulus(8'h3C);
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out",  {31'b0, out0},  32'd1);
    checkOutput("rst_busy", {31'b0, busy0}, 32'd0);
    checkOutput("rst_rdy",  {31'b0, rdy0},  32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_rdy", {31'b0, rdy0}, 32'd1);
    applyStimulus(8'hFF);
    captureFrame(44);
    checkOutput("ff_bits", {21'b0, slowBits()}, (PB == 1) ? 32'h5FE : 32'h3FE);
    waitIdle();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parallel-to-serial frame transmitter. Accepts one `DATA_W`-bit word per valid/ready handshake and shifts it out LSB-first on a single line, framed by a start bit (0) and a stop bit (1). An optional even-parity bit can be added. It pairs with the team's flip-flop-based serial capture logic, which samples `tx_out` at the far end.

## Interface
- `DATA_W`, default 8: payload width in bits; must be at least 1.
- `BAUD_DIV`, default 4: clock cycles per serial bit; must be at least 1.
- `clk`  input  1  the single clock; all state changes on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `tx_data`  input  `DATA_W`  payload word; sampled only on handshake.
- `tx_valid`  input  1  source has a word to send.
- `tx_ready`  output  1  block can accept a word this cycle.
- `tx_out`  output  1  serial line; idles high.
- `busy`  output  1  a frame is in progress (any state other than IDLE).

## Operation
- States:
  - IDLE → START on handshake (`tx_valid && tx_ready` at a rising edge).
  - START → DATA.
  - DATA → PARITY (if compiled in) or STOP, after `DATA_W` bits.
  - PARITY → STOP.
  - STOP → IDLE, or STOP → START on a back-to-back handshake.
- Each state other than IDLE lasts `BAUD_DIV` cycles per bit. A divider counter of width clog2(`BAUD_DIV`), min 1, advances the bit. DATA uses a bit counter from 0 to `DATA_W-1`.
- On handshake, `tx_data` is loaded into a shift register. Each DATA bit period shifts it right by one, and `tx_out` carries bit 0.
- `tx_out` is registered:
  - 0 in START;
  - shift-register bit 0 in DATA;
  - parity in PARITY;
  - 1 in STOP and IDLE.
- `tx_ready` is combinational: high in IDLE, and in the final cycle of STOP, and only when `rst` is low. A handshake in the final STOP cycle goes directly to START with no idle gap.
- `tx_data` is ignored outside the handshake cycle. `tx_valid` may drop without a handshake; no state change results.
- Reset values: state IDLE, `tx_out`=1, `busy`=0, counters 0, shift register 0. `tx_ready` is 0 while `rst`=1 and 1 in the first cycle after.
- Reset mid-frame aborts the frame: `tx_out` returns to 1 at the reset edge. No partial word is resumed.

## Timing
- Handshake at edge N: `tx_out` falls at edge N, `busy` rises at edge N.
- Frame length is (2 + `DATA_W` + P) × `BAUD_DIV` cycles, where P = 1 with parity and 0 without. With defaults and no parity: 40 cycles.
- Data bit k is driven from edge N+(1+k)×`BAUD_DIV` for `BAUD_DIV` cycles.
- Back-to-back frames are spaced exactly one frame length apart, with no extra idle cycle.
- `BAUD_DIV`=1: one bit per clock. `tx_ready` is high only in the single STOP cycle while a frame is running.

## Configuration
- `SERIAL_TX_PARITY_EN`:
  - Defined: adds a PARITY state between DATA and STOP. The driven bit is the XOR of the loaded word (even parity); frame length grows by `BAUD_DIV`.
  - Undefined: DATA goes straight to STOP, and no parity logic exists.

## Structure
- Shared package `serial_pkg`:
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits);
  - `START_BIT`=0, `STOP_BIT`=1, `IDLE_LEVEL`=1.
  - The matching serial receiver uses the same package.
- One sub-module, `baud_tick_gen`: divider counter with synchronous clear. It emits a one-cycle `bit_end` pulse on the final cycle of each bit period and is cleared on handshake and on `rst`.

## Test plan
- Reset, then idle for 10 cycles → `tx_out`=1, `busy`=0, `tx_ready`=1 throughout; `tx_ready`=0 while `rst`=1.
- `tx_data`=0xA5, defaults, no parity → `tx_out` bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `busy` lasts 40 cycles; `tx_ready` is high only in cycle 40.
- With `SERIAL_TX_PARITY_EN`: 0xA5 → parity bit 0, frame 44 cycles. 0x07 → parity bit 1.
- `tx_valid` held high with 0x01 then 0x80 → second start bit begins exactly 40 cycles after the first, with no idle gap.
- `rst` pulsed in cycle 15 of a frame → `tx_out`=1 and `busy`=0 at that edge. A new word of 0xFF then produces a clean full frame.
- `BAUD_DIV`=1, `DATA_W`=4, 0x9 → `tx_out` 0,1,0,0,1,1 on consecutive cycles.
